ibuffer: RTL

IBUFFER -- requirements
Module: ibuffer

---
 rtl/global_config_pkg.sv | 15 +
 rtl/ibuffer.sv | 78 +++++++
 2 files changed

// File: rtl/global_config_pkg.sv
// global_config_pkg: shared core widths, instruction-buffer defaults and the buffer entry type.
package global_config_pkg;

    localparam int CFG_ILEN             = 32;
    localparam int CFG_PLEN             = 32;
    localparam int IBUF_DEPTH           = 16;
    localparam int IBUF_DECODE_WIDTH    = 2;
    localparam int IBUF_INSTR_PER_FETCH = 4;

    typedef struct packed {
        logic [CFG_ILEN-1:0] instr;
        logic [CFG_PLEN-1:0] pc;
    } ibuf_entry_t;

endpackage

// File: rtl/ibuffer.sv
// ibuffer: circular FIFO between IFU fetch groups and decode; IBUFFER_BYPASS_EN adds an empty-buffer
// same-cycle path from ifu_rsp_* to dec_*.
module ibuffer
    import global_config_pkg::*;
#(
    parameter int INSTR_PER_FETCH = IBUF_INSTR_PER_FETCH,
    parameter int DECODE_WIDTH    = IBUF_DECODE_WIDTH,
    parameter int DEPTH           = IBUF_DEPTH,
    parameter int ILEN            = CFG_ILEN,
    parameter int PLEN            = CFG_PLEN
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush_i,
    input  logic                                   ifu_rsp_valid_i,
    output logic                                   ifu_rsp_ready_o,
    input  logic [PLEN-1:0]                        ifu_rsp_pc_i,
    input  logic [INSTR_PER_FETCH-1:0][ILEN-1:0]   ifu_rsp_data_i,
    output logic [DECODE_WIDTH-1:0]                dec_valid_o,
    input  logic                                   dec_ready_i,
    output logic [DECODE_WIDTH-1:0][ILEN-1:0]      dec_instr_o,
    output logic [DECODE_WIDTH-1:0][PLEN-1:0]      dec_pc_o,
    output logic [$clog2(DEPTH+1)-1:0]             count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int NB = INSTR_PER_FETCH < DECODE_WIDTH ? INSTR_PER_FETCH : DECODE_WIDTH;

    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, n, skip;
    logic          enq, byp;
    ibuf_entry_t   mem [DEPTH];

    assign ifu_rsp_ready_o = !rst && !flush_i && count_q <= CW'(DEPTH - INSTR_PER_FETCH);
    assign enq             = ifu_rsp_valid_i && ifu_rsp_ready_o;
    assign count_o         = count_q;

`ifdef IBUFFER_BYPASS_EN
    assign byp = enq && count_q == '0;
`else
    assign byp = 1'b0;
`endif

    // bypassed slots consumed by decode this cycle never reach the FIFO
    assign skip = byp && dec_ready_i ? CW'(NB) : '0;
    assign n    = dec_ready_i && !byp ? (count_q < CW'(DECODE_WIDTH) ? count_q : CW'(DECODE_WIDTH)) : '0;

    for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_slot
        localparam int J = i < INSTR_PER_FETCH ? i : 0;
        localparam bit B = i < NB;
        logic [AW-1:0] idx;
        assign idx            = head_q + AW'(i);
        assign dec_valid_o[i] = (byp && B) || (!rst && !flush_i && count_q > CW'(i));
        assign dec_instr_o[i] = byp && B ? ifu_rsp_data_i[J] : mem[idx].instr;
        assign dec_pc_o[i]    = byp && B ? ifu_rsp_pc_i + PLEN'(4*J) : mem[idx].pc;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + AW'(n);
            tail_q  <= tail_q + (enq ? AW'(INSTR_PER_FETCH) - AW'(skip) : '0);
            count_q <= count_q + (enq ? CW'(INSTR_PER_FETCH) - skip : '0) - n;
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            for (int k = 0; k < INSTR_PER_FETCH; k++)
                if (CW'(k) >= skip)
                    mem[tail_q + AW'(k) - AW'(skip)] <= '{instr: ifu_rsp_data_i[k], pc: ifu_rsp_pc_i + PLEN'(4*k)};
    end

endmodule
